// File: rtl/vga_cursor_timing_if.sv
// Bundle of the raw button inputs and the DAC-facing video outputs of vga_cursor_timing.
// Video is a free-running stream: no valid/ready. Every clk_25mhz cycle carries one pixel; the sink cannot stall it.
interface vga_cursor_timing_if #(
  parameter int COORD_W = 10
);
  logic               up;
  logic               down;
  logic               left;
  logic               right;
  logic               hsync;
  logic               vsync;
  logic               comp_sync;
  logic               blank;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic [7:0]         pixel_r;
  logic [7:0]         pixel_g;
  logic [7:0]         pixel_b;
  logic               frame_start;
  logic [COORD_W-1:0] cursor_x;
  logic [COORD_W-1:0] cursor_y;

  modport master (
    input  up, down, left, right,
    output hsync, vsync, comp_sync, blank, pixel_x, pixel_y,
    output pixel_r, pixel_g, pixel_b, frame_start, cursor_x, cursor_y
  );

  modport slave (
    output up, down, left, right,
    input  hsync, vsync, comp_sync, blank, pixel_x, pixel_y,
    input  pixel_r, pixel_g, pixel_b, frame_start, cursor_x, cursor_y
  );
endinterface

// File: rtl/vga_cursor_timing.sv
// Parametrised VGA timing generator with a button-driven square cursor overlay.
// All video outputs are registered one cycle behind the hcnt/vcnt counters.
module vga_cursor_timing #(
  parameter int          H_ACTIVE    = 640,
  parameter int          H_FP        = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BP        = 48,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_FP        = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_BP        = 33,
  parameter bit          HSYNC_POL   = 1'b0,
  parameter bit          VSYNC_POL   = 1'b0,
  parameter int          COORD_W     = 10,
  parameter int          CURSOR_SIZE = 8,
  parameter int          STEP        = 1,
  parameter bit          WRAP        = 1'b0,
  parameter logic [23:0] CURSOR_RGB  = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB      = 24'h000080
) (
  input  logic                 clk_25mhz,
  input  logic                 rst,
  vga_cursor_timing_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_MAX   = H_ACTIVE - CURSOR_SIZE;
  localparam int Y_MAX   = V_ACTIVE - CURSOR_SIZE;
  localparam int CW      = COORD_W + 1;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] CX0      = COORD_W'(X_MAX / 2);
  localparam logic [COORD_W-1:0] CY0      = COORD_W'(Y_MAX / 2);
  localparam logic [CW-1:0]      X_LIM    = CW'(X_MAX);
  localparam logic [CW-1:0]      Y_LIM    = CW'(Y_MAX);
  localparam logic [CW-1:0]      STEP_W   = CW'(STEP);
  localparam logic [CW-1:0]      SIZE_W   = CW'(CURSOR_SIZE);

  logic [COORD_W-1:0] hcnt;
  logic [COORD_W-1:0] vcnt;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  // Button bits ordered {up, down, left, right}.
  logic [3:0]         btn_meta;
  logic [3:0]         btn_sync;

  logic          h_wrap;
  logic          v_wrap;
  logic          visible;
  logic          hs_act;
  logic          vs_act;
  logic          hit;
  logic          upd;
  logic [CW-1:0] x_end;
  logic [CW-1:0] y_end;

  // One axis step; the extra bit keeps the overflow test free of modular wrap.
  function automatic logic [COORD_W-1:0] step_axis(
    input logic [COORD_W-1:0] pos,
    input logic               inc,
    input logic               dec,
    input logic [CW-1:0]      lim
  );
    logic [CW-1:0] p;
    logic [CW-1:0] s;
    p = {1'b0, pos};
    s = p + STEP_W;
    step_axis = pos;
    if (inc && !dec) begin
      if (s > lim) step_axis = WRAP ? '0 : lim[COORD_W-1:0];
      else         step_axis = s[COORD_W-1:0];
    end else if (dec && !inc) begin
      if (p < STEP_W) step_axis = WRAP ? lim[COORD_W-1:0] : '0;
      else            step_axis = pos - STEP_W[COORD_W-1:0];
    end
  endfunction

  always_comb begin
    h_wrap  = (hcnt == H_LAST);
    v_wrap  = (vcnt == V_LAST);
    visible = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
    hs_act  = (hcnt >= HS_START) && (hcnt < HS_END);
    vs_act  = (vcnt >= VS_START) && (vcnt < VS_END);
    x_end   = {1'b0, cur_x} + SIZE_W;
    y_end   = {1'b0, cur_y} + SIZE_W;
    hit     = (hcnt >= cur_x) && ({1'b0, hcnt} < x_end) &&
              (vcnt >= cur_y) && ({1'b0, vcnt} < y_end);
    upd     = (vcnt == V_ACT_C) && (hcnt == '0);
  end

  always_ff @(posedge clk_25mhz or negedge rst) begin
    if (!rst) begin
      hcnt            <= '0;
      vcnt            <= '0;
      btn_meta        <= '0;
      btn_sync        <= '0;
      cur_x           <= CX0;
      cur_y           <= CY0;
      vga.hsync       <= ~HSYNC_POL;
      vga.vsync       <= ~VSYNC_POL;
      vga.comp_sync   <= 1'b1;
      vga.blank       <= 1'b0;
      vga.pixel_x     <= '0;
      vga.pixel_y     <= '0;
      vga.pixel_r     <= '0;
      vga.pixel_g     <= '0;
      vga.pixel_b     <= '0;
      vga.frame_start <= 1'b0;
    end else begin
      btn_meta <= {vga.up, vga.down, vga.left, vga.right};
      btn_sync <= btn_meta;
      hcnt     <= h_wrap ? '0 : hcnt + 1'b1;
      if (h_wrap) vcnt <= v_wrap ? '0 : vcnt + 1'b1;
      // The update line is vertical blanking, so a move never tears the image.
      if (upd) begin
        cur_x <= step_axis(cur_x, btn_sync[0], btn_sync[1], X_LIM);
        cur_y <= step_axis(cur_y, btn_sync[2], btn_sync[3], Y_LIM);
      end
      vga.hsync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vga.vsync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      vga.comp_sync   <= ~(hs_act | vs_act);
      vga.blank       <= visible;
      vga.pixel_x     <= hcnt;
      vga.pixel_y     <= vcnt;
      {vga.pixel_r, vga.pixel_g, vga.pixel_b} <= visible ? (hit ? CURSOR_RGB : BG_RGB) : 24'h0;
      vga.frame_start <= (hcnt == '0) && (vcnt == '0);
    end
  end

  assign vga.cursor_x = cur_x;
  assign vga.cursor_y = cur_y;

endmodule

// File: tb/tb_vga_cursor_timing.sv
// Directed bench: default timing line checks plus scaled-down instances for frame, cursor and reset behaviour.
module tb_vga_cursor_timing;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [9:0] exp_q[$];

  // Default 640x480 instance, medium clamp/wrap pair, STEP=4 wrap, tiny frame.
  vga_cursor_timing_if #(.COORD_W(10)) vd();
  vga_cursor_timing_if #(.COORD_W(7))  vc();
  vga_cursor_timing_if #(.COORD_W(7))  vw();
  vga_cursor_timing_if #(.COORD_W(7))  vs();
  vga_cursor_timing_if #(.COORD_W(4))  vt();

  vga_cursor_timing u_def (.clk_25mhz(clk), .rst(rst), .vga(vd));

  vga_cursor_timing #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .COORD_W(7), .CURSOR_SIZE(4), .STEP(1), .WRAP(1'b0)
  ) u_clamp (.clk_25mhz(clk), .rst(rst), .vga(vc));

  vga_cursor_timing #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .COORD_W(7), .CURSOR_SIZE(4), .STEP(1), .WRAP(1'b1)
  ) u_wrap (.clk_25mhz(clk), .rst(rst), .vga(vw));

  vga_cursor_timing #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(22), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .COORD_W(7), .CURSOR_SIZE(4), .STEP(4), .WRAP(1'b1)
  ) u_step4 (.clk_25mhz(clk), .rst(rst), .vga(vs));

  vga_cursor_timing #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .COORD_W(4), .CURSOR_SIZE(2)
  ) u_tiny (.clk_25mhz(clk), .rst(rst), .vga(vt));

  // Clock and reset
  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cx(input string tag);
    logic [9:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
    check(tag, 32'(vc.cursor_x), 32'(e));
  endtask

  task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
    vc.up = u; vc.down = d; vc.left = l; vc.right = r;
    vw.up = u; vw.down = d; vw.left = l; vw.right = r;
  endtask

  task automatic wait_fs_c();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vc.frame_start && n < 3000);
    if (!vc.frame_start) check("timeout_fs_c", 32'(vc.frame_start), 32'd1);
  endtask

  task automatic wait_fs_s();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vs.frame_start && n < 3000);
    if (!vs.frame_start) check("timeout_fs_s", 32'(vs.frame_start), 32'd1);
  endtask

  task automatic wait_pix_c(input int x, input int y);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(int'(vc.pixel_x) == x && int'(vc.pixel_y) == y) && n < 3000);
    if (n >= 3000) check("timeout_pix_c", 32'(vc.pixel_x), 32'(x));
  endtask

  initial begin
    int fall0, fall1, fall_px, low_run, prev_hs, d_blank;
    int bad_blank, bad_comp, bad_vs, bad_ths, bad_tvs, bad_tfs;
    int m_blank, m_fs_n, m_fs2, t_last, t_fs_n;
    logic [23:0] rgb_a, rgb_b, rgb_c, rgb_d;

    n_checks = 0; n_errors = 0;
    fall0 = -1; fall1 = -1; fall_px = -1; low_run = 0; prev_hs = 1; d_blank = 0;
    bad_blank = 0; bad_comp = 0; bad_vs = 0; bad_ths = 0; bad_tvs = 0; bad_tfs = 0;
    m_blank = 0; m_fs_n = 0; m_fs2 = -1; t_last = -1; t_fs_n = 0;
    rgb_a = '1; rgb_b = '1; rgb_c = '1; rgb_d = '1;
    set_btn(0, 0, 0, 0);
    vs.up = 0; vs.down = 0; vs.left = 0; vs.right = 0;
    vd.up = 0; vd.down = 0; vd.left = 0; vd.right = 0;
    vt.up = 0; vt.down = 0; vt.left = 0; vt.right = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_hsync", 32'(vd.hsync), 32'd1);
    check("rst_vsync", 32'(vd.vsync), 32'd1);
    check("rst_comp", 32'(vd.comp_sync), 32'd1);
    check("rst_blank", 32'(vd.blank), 32'd0);
    check("rst_rgb", 32'({vd.pixel_r, vd.pixel_g, vd.pixel_b}), 32'd0);
    check("rst_px", 32'(vd.pixel_x), 32'd0);
    check("rst_py", 32'(vd.pixel_y), 32'd0);
    check("rst_fs", 32'(vd.frame_start), 32'd0);
    check("rst_cx", 32'(vd.cursor_x), 32'd316);
    check("rst_cy", 32'(vd.cursor_y), 32'd236);
    check("rst_tiny_hsync", 32'(vt.hsync), 32'd0);
    check("rst_tiny_cx", 32'(vt.cursor_x), 32'd3);
    check("rst_tiny_cy", 32'(vt.cursor_y), 32'd1);
    check("rst_mid_cx", 32'(vc.cursor_x), 32'd14);
    check("rst_mid_cy", 32'(vc.cursor_y), 32'd8);
    check("rst_s4_cy", 32'(vs.cursor_y), 32'd9);

    rst = 1'b1;
    @(negedge clk);
    check("first_fs", 32'(vd.frame_start), 32'd1);
    check("first_px", 32'(vd.pixel_x), 32'd0);
    check("first_blank", 32'(vd.blank), 32'd1);
    check("first_rgb", 32'({vd.pixel_r, vd.pixel_g, vd.pixel_b}), 32'h000080);

    // Free-running observation window: first two default lines, first medium frame, tiny frames
    for (int c = 0; c < 1500; c++) begin
      if (c > 0) @(negedge clk);
      if (prev_hs == 1 && vd.hsync == 1'b0) begin
        if (fall0 < 0) begin fall0 = c; fall_px = int'(vd.pixel_x); end
        else if (fall1 < 0) fall1 = c;
      end
      if (vd.hsync == 1'b0 && fall1 < 0) low_run++;
      prev_hs = int'(vd.hsync);
      if (vd.blank) d_blank++;
      if (!vd.blank && {vd.pixel_r, vd.pixel_g, vd.pixel_b} != 24'h0) bad_blank++;
      if (!vc.blank && {vc.pixel_r, vc.pixel_g, vc.pixel_b} != 24'h0) bad_blank++;
      if (!vt.blank && {vt.pixel_r, vt.pixel_g, vt.pixel_b} != 24'h0) bad_blank++;
      if ((!vd.hsync || !vd.vsync) && vd.comp_sync) bad_comp++;
      if ((!vc.hsync || !vc.vsync) && vc.comp_sync) bad_comp++;
      if (vc.vsync !== !(vc.pixel_y >= 7'd22 && vc.pixel_y < 7'd24)) bad_vs++;
      if (vc.frame_start) begin
        m_fs_n++;
        if (c > 0 && m_fs2 < 0) m_fs2 = c;
      end
      if (c < 1296 && vc.blank) m_blank++;
      if (c < 1296) begin
        if (vc.pixel_x == 7'd14 && vc.pixel_y == 7'd8)  rgb_a = {vc.pixel_r, vc.pixel_g, vc.pixel_b};
        if (vc.pixel_x == 7'd18 && vc.pixel_y == 7'd8)  rgb_b = {vc.pixel_r, vc.pixel_g, vc.pixel_b};
        if (vc.pixel_x == 7'd13 && vc.pixel_y == 7'd11) rgb_c = {vc.pixel_r, vc.pixel_g, vc.pixel_b};
        if (vc.pixel_x == 7'd17 && vc.pixel_y == 7'd11) rgb_d = {vc.pixel_r, vc.pixel_g, vc.pixel_b};
      end
      if (vt.hsync !== (vt.pixel_x >= 4'd9 && vt.pixel_x <= 4'd10)) bad_ths++;
      if (vt.vsync !== (vt.pixel_y != 4'd5)) bad_tvs++;
      if (vt.frame_start) begin
        if (t_last >= 0 && c - t_last != 84) bad_tfs++;
        t_last = c;
        t_fs_n++;
      end
    end

    check("hs_fall_px", 32'(fall_px), 32'd656);
    check("hs_low_run", 32'(low_run), 32'd96);
    check("hs_period", 32'(fall1 - fall0), 32'd800);
    check("def_blank_2lines", 32'(d_blank), 32'd1280);
    check("blank_rgb_zero", 32'(bad_blank), 32'd0);
    check("comp_sync_low", 32'(bad_comp), 32'd0);
    check("mid_vsync_lines", 32'(bad_vs), 32'd0);
    check("mid_frame_len", 32'(m_fs2), 32'd1296);
    check("mid_fs_count", 32'(m_fs_n), 32'd2);
    check("mid_blank_count", 32'(m_blank), 32'd640);
    check("rgb_cursor_tl", 32'(rgb_a), 32'hFFFFFF);
    check("rgb_right_of", 32'(rgb_b), 32'h000080);
    check("rgb_left_of", 32'(rgb_c), 32'h000080);
    check("rgb_cursor_br", 32'(rgb_d), 32'hFFFFFF);
    check("tiny_hsync_pos", 32'(bad_ths), 32'd0);
    check("tiny_vsync_line", 32'(bad_tvs), 32'd0);
    check("tiny_frame_84", 32'(bad_tfs), 32'd0);
    check("tiny_fs_count", 32'(t_fs_n), 32'd18);

    // Cursor motion on the clamp/wrap pair
    exp_q.push_back(10'd15);
    exp_q.push_back(10'd15);
    exp_q.push_back(10'd15);
    exp_q.push_back(10'd16);
    exp_q.push_back(10'd28);
    exp_q.push_back(10'd28);

    wait_fs_c();
    set_btn(0, 0, 0, 1);
    wait_fs_c();
    set_btn(0, 0, 0, 0);
    check_cx("right_one_c");
    check("right_one_w", 32'(vw.cursor_x), 32'd15);
    check("right_one_y", 32'(vc.cursor_y), 32'd8);

    set_btn(0, 0, 1, 1);
    wait_fs_c();
    set_btn(0, 0, 0, 0);
    check_cx("left_right_c");

    wait_pix_c(46, 19);
    set_btn(0, 0, 0, 1);
    repeat (2) @(negedge clk);
    set_btn(0, 0, 0, 0);
    wait_fs_c();
    check_cx("pulse2_c");

    wait_pix_c(45, 19);
    set_btn(0, 0, 0, 1);
    repeat (3) @(negedge clk);
    set_btn(0, 0, 0, 0);
    wait_fs_c();
    check_cx("pulse3_c");
    check("pulse3_w", 32'(vw.cursor_x), 32'd16);

    set_btn(0, 0, 0, 1);
    repeat (12) wait_fs_c();
    check_cx("at_xmax_c");
    check("at_xmax_w", 32'(vw.cursor_x), 32'd28);
    wait_fs_c();
    set_btn(0, 0, 0, 0);
    check_cx("clamp_right_c");
    check("wrap_right_w", 32'(vw.cursor_x), 32'd0);

    // STEP=4 wrap on the vertical axis: 9 -> 5 -> 1 -> Y_MAX
    wait_fs_s();
    vs.up = 1'b1;
    repeat (2) wait_fs_s();
    check("s4_up_two", 32'(vs.cursor_y), 32'd1);
    wait_fs_s();
    vs.up = 1'b0;
    check("s4_wrap_up", 32'(vs.cursor_y), 32'd18);

    // Asynchronous reset in the middle of a visible line
    wait_pix_c(30, 5);
    check("pre_rst_blank", 32'(vc.blank), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_px", 32'(vc.pixel_x), 32'd0);
    check("arst_py", 32'(vc.pixel_y), 32'd0);
    check("arst_blank", 32'(vc.blank), 32'd0);
    check("arst_rgb", 32'({vc.pixel_r, vc.pixel_g, vc.pixel_b}), 32'd0);
    check("arst_hsync", 32'(vc.hsync), 32'd1);
    check("arst_comp", 32'(vc.comp_sync), 32'd1);
    check("arst_fs", 32'(vc.frame_start), 32'd0);
    check("arst_cx_c", 32'(vc.cursor_x), 32'd14);
    check("arst_cx_w", 32'(vw.cursor_x), 32'd14);
    check("arst_cy_s", 32'(vs.cursor_y), 32'd9);
    repeat (3) @(negedge clk);
    check("arst_hold_px", 32'(vc.pixel_x), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_fs_c", 32'(vc.frame_start), 32'd1);
    check("rel_fs_d", 32'(vd.frame_start), 32'd1);
    check("rel_fs_t", 32'(vt.frame_start), 32'd1);
    check("rel_px", 32'(vc.pixel_x), 32'd0);
    @(negedge clk);
    check("rel_px_next", 32'(vc.pixel_x), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
